// File: rtl/eth_fcs_tx_ctrl.sv
// Ethernet transmit FCS sequencer: passes frame bytes, zero-pads short frames
// to MIN_FRAME bytes and appends the 4-byte CRC-32 FCS, least-significant first.
// Also contains the 8-bit-per-cycle CRC-32 engine that the sequencer drives.

module eth_fcs_crc32_d8 (
    input  logic        clk_i,
    input  logic        arst_n_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  d_i,
    output logic [31:0] crc_o
);
    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic [31:0] crc_q, crc_d;

    // One byte of MSB-first polynomial division, d_i[7] enters first
    always_comb begin
        crc_d = crc_q;
        for (int i = 7; i >= 0; i--) begin
            if (crc_d[31] ^ d_i[i]) crc_d = (crc_d << 1) ^ POLY;
            else                    crc_d = crc_d << 1;
        end
    end

    // CRC register: clear reseeds to all-ones and outranks enable
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)  crc_q <= '1;
        else if (clr_i) crc_q <= '1;
        else if (en_i)  crc_q <= crc_d;
    end

    assign crc_o = crc_q;
endmodule

module eth_fcs_tx_ctrl #(
    parameter int MIN_FRAME = 60,   // 0 disables padding
    parameter int CNT_W     = 16    // kept below 31 so the count fits an int compare
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [CNT_W-1:0] frames_sent,
    output logic             busy
);
    typedef enum logic [1:0] {ST_DATA, ST_PAD, ST_FCS} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] frames_q, frames_d;

    logic             crc_en, crc_clr;
    logic [7:0]       crc_byte;
    logic [31:0]      crc, fcs;
    logic [CNT_W-1:0] cnt_sat;
    logic             reach_min;

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    // Async reset of the engine is unused; every reseed goes through clear
    eth_fcs_crc32_d8 u_crc (
        .clk_i    (CLK),
        .arst_n_i (1'b1),
        .clr_i    (RST | crc_clr),
        .en_i     (crc_en & ~RST),
        .d_i      (rev8(crc_byte)),
        .crc_o    (crc)
    );

    assign fcs     = ~rev32(crc);
    assign cnt_sat = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    // Signed compare keeps MIN_FRAME = 0 from collapsing to a constant test
    assign reach_min = (int'(cnt_q) + 1) >= MIN_FRAME;
    assign busy        = (state_q != ST_DATA) || (cnt_q != '0);
    assign frames_sent = frames_q;

    // Next-state and output decode; RST blanks both handshake sides
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        frames_d = frames_q;
        crc_en   = 1'b0;
        crc_clr  = 1'b0;
        crc_byte = 8'h00;
        s_ready  = 1'b0;
        m_valid  = 1'b0;
        m_last   = 1'b0;
        m_data   = 8'h00;
        case (state_q)
            ST_DATA: begin
                m_data   = s_data;
                m_valid  = s_valid;
                s_ready  = m_ready;
                crc_byte = s_data;
                if (s_valid && m_ready) begin
                    crc_en = 1'b1;
                    cnt_d  = cnt_sat;
                    if (s_last) state_d = reach_min ? ST_FCS : ST_PAD;
                end
            end
            ST_PAD: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    crc_en = 1'b1;
                    cnt_d  = cnt_sat;
                    if (reach_min) state_d = ST_FCS;
                end
            end
            ST_FCS: begin
                m_valid = 1'b1;
                m_data  = fcs[{idx_q, 3'b000} +: 8];
                m_last  = (idx_q == 2'd3);
                if (m_ready) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        crc_clr  = 1'b1;
                        cnt_d    = '0;
                        idx_d    = '0;
                        frames_d = frames_q + 1'b1;
                        state_d  = ST_DATA;
                    end
                end
            end
            default: state_d = ST_DATA;
        endcase
        if (RST) begin
            s_ready = 1'b0;
            m_valid = 1'b0;
            m_last  = 1'b0;
            m_data  = 8'h00;
        end
    end

    // State, counters and FCS index registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_DATA;
            cnt_q    <= '0;
            idx_q    <= '0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            frames_q <= frames_d;
        end
    end
endmodule

// File: tb/tb_eth_fcs_tx_ctrl.sv
// Bench for eth_fcs_tx_ctrl: two instances (MIN_FRAME 0 and 60), a scoreboard
// fed at stimulus time from a reflected-CRC software model, and a monitor
// that pops and compares on every output transfer.

module tb_eth_fcs_tx_ctrl;
    typedef logic [7:0] q8_t[$];
    typedef logic [8:0] q9_t[$];

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic [7:0]  s_data [2];
    logic        s_valid[2], s_last[2], s_ready[2];
    logic [7:0]  m_data [2];
    logic        m_valid[2], m_last[2], m_ready[2];
    logic [15:0] frames [2];
    logic        busy   [2];

    eth_fcs_tx_ctrl #(.MIN_FRAME(0), .CNT_W(16)) dut0 (
        .CLK(CLK), .RST(RST), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]),
        .s_ready(s_ready[0]), .m_data(m_data[0]), .m_valid(m_valid[0]), .m_last(m_last[0]),
        .m_ready(m_ready[0]), .frames_sent(frames[0]), .busy(busy[0]));

    eth_fcs_tx_ctrl #(.MIN_FRAME(60), .CNT_W(16)) dut1 (
        .CLK(CLK), .RST(RST), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]),
        .s_ready(s_ready[1]), .m_data(m_data[1]), .m_valid(m_valid[1]), .m_last(m_last[1]),
        .m_ready(m_ready[1]), .frames_sent(frames[1]), .busy(busy[1]));

    q9_t  q0, q1;
    q8_t  cap0, cap1;
    int   exp_frames[2];
    bit   rnd_rdy[2];
    bit   hold[2];
    logic [7:0] hd[2];
    logic hl[2];
    int   checks = 0, failures = 0;

    // Reference CRC-32: reflected form, LSB-first, poly 0xEDB88320, no final invert
    function automatic logic [31:0] crc_ref(input q8_t b);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'd0, b[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    function automatic q9_t to_st(input q8_t pl);
        q9_t s;
        foreach (pl[i]) s.push_back({i == pl.size() - 1, pl[i]});
        return s;
    endfunction

    function automatic q8_t kv_payload();
        q8_t p;
        for (int i = 0; i < 9; i++) p.push_back(8'h31 + 8'(i));
        return p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, want %h", nm, act, req);
        end
    endtask

    task automatic push_exp(input int k, input logic [8:0] v);
        if (k == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    // Known-answer frame: bytes as given, m_last on the final one
    task automatic push_raw(input int k, input q8_t b);
        foreach (b[i]) push_exp(k, {i == b.size() - 1, b[i]});
        exp_frames[k]++;
    endtask

    // Model frame: pad with zeros to minf, then FCS = ~crc, LSB first
    task automatic push_frame(input int k, input q8_t pl, input int minf);
        q8_t f;
        logic [31:0] fcs;
        f = pl;
        while (f.size() < minf) f.push_back(8'h00);
        fcs = ~crc_ref(f);
        foreach (f[i]) push_exp(k, {1'b0, f[i]});
        for (int i = 0; i < 4; i++) push_exp(k, {i == 3, fcs[8*i +: 8]});
        exp_frames[k]++;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Source driver: holds each byte until s_ready is seen, optional idle gaps
    task automatic send(input int k, input q9_t st, input int idle_pct);
        foreach (st[i]) begin
            if (idle_pct > 0 && int'($urandom_range(0, 99)) < idle_pct) begin
                s_valid[k] = 1'b0;
                step();
            end
            s_data[k]  = st[i][7:0];
            s_last[k]  = st[i][8];
            s_valid[k] = 1'b1;
            begin
                int n;
                n = 0;
                forever begin
                    @(negedge CLK);
                    if (s_ready[k]) break;
                    n++;
                    if (n > 2000) begin
                        checks++; failures++;
                        $display("FAIL send_timeout dut%0d: got no s_ready, want acceptance", k);
                        break;
                    end
                end
            end
            step();
        end
        s_valid[k] = 1'b0;
        s_last[k]  = 1'b0;
    endtask

    task automatic wait_drain(input int k);
        int n;
        n = 0;
        while ((k == 0 ? q0.size() : q1.size()) != 0) begin
            @(negedge CLK);
            n++;
            if (n > 5000) begin
                checks++; failures++;
                $display("FAIL drain_timeout dut%0d: got %0d pending, want 0", k, (k == 0 ? q0.size() : q1.size()));
                if (k == 0) q0.delete(); else q1.delete();
                break;
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic mon(input int k);
        logic [8:0] e;
        if (RST) begin
            chk($sformatf("rst_outputs dut%0d", k), {21'd0, s_ready[k], m_valid[k], m_last[k], m_data[k]}, 32'd0);
            hold[k] = 1'b0;
            if (k == 0) cap0.delete(); else cap1.delete();
            return;
        end
        if (hold[k])
            chk($sformatf("hold_stable dut%0d", k), {22'd0, m_valid[k], m_last[k], m_data[k]}, {22'd0, 1'b1, hl[k], hd[k]});
        hold[k] = m_valid[k] && !m_ready[k];
        hd[k]   = m_data[k];
        hl[k]   = m_last[k];
        if (m_valid[k] && m_ready[k]) begin
            if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                checks++; failures++;
                $display("FAIL out_unexpected dut%0d: got %h, want no output", k, {m_last[k], m_data[k]});
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("out_byte dut%0d", k), {23'd0, m_last[k], m_data[k]}, {23'd0, e});
            end
            if (k == 0) cap0.push_back(m_data[k]); else cap1.push_back(m_data[k]);
            if (m_last[k]) begin
                chk($sformatf("residue dut%0d", k), rev32(crc_ref(k == 0 ? cap0 : cap1)), 32'hC704DD7B);
                if (k == 0) cap0.delete(); else cap1.delete();
            end
        end
    endtask

    initial begin
        q8_t pl, ex;
        q9_t st;
        RST = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s_data[k] = 8'h00; s_valid[k] = 1'b0; s_last[k] = 1'b0;
            m_ready[k] = 1'b1; rnd_rdy[k] = 1'b0; hold[k] = 1'b0; exp_frames[k] = 0;
        end
        fork
            forever begin
                @(negedge CLK);
                mon(0);
                mon(1);
            end
            forever begin
                step();
                for (int k = 0; k < 2; k++)
                    m_ready[k] = rnd_rdy[k] ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        join_none

        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_frames dut%0d", k), 32'(frames[k]), 32'd0);
            chk($sformatf("reset_busy dut%0d", k), 32'(busy[k]), 32'd0);
        end
        step();

        // Check value "123456789", no padding
        pl = kv_payload();
        ex = pl;
        ex.push_back(8'h26); ex.push_back(8'h39); ex.push_back(8'hF4); ex.push_back(8'hCB);
        push_raw(0, ex);
        send(0, to_st(pl), 0);
        wait_drain(0);
        chk("kv_frames", 32'(frames[0]), 32'(exp_frames[0]));
        chk("kv_busy_idle", 32'(busy[0]), 32'd0);
        step();

        // Single zero byte
        pl.delete(); pl.push_back(8'h00);
        ex = pl;
        ex.push_back(8'h8D); ex.push_back(8'hEF); ex.push_back(8'h02); ex.push_back(8'hD2);
        push_raw(0, ex);
        send(0, to_st(pl), 0);
        wait_drain(0);
        chk("zero_frames", 32'(frames[0]), 32'(exp_frames[0]));
        step();

        // Short frame padded to 60 bytes
        pl.delete(); pl.push_back(8'h01); pl.push_back(8'h02); pl.push_back(8'h03);
        push_frame(1, pl, 60);
        chk("pad_queue_len", q1.size(), 32'd64);
        send(1, to_st(pl), 0);
        @(negedge CLK);
        chk("pad_busy", 32'(busy[1]), 32'd1);
        wait_drain(1);
        chk("pad_frames", 32'(frames[1]), 32'(exp_frames[1]));
        chk("pad_busy_idle", 32'(busy[1]), 32'd0);
        step();

        // Check value under random backpressure
        pl = kv_payload();
        ex = pl;
        ex.push_back(8'h26); ex.push_back(8'h39); ex.push_back(8'hF4); ex.push_back(8'hCB);
        rnd_rdy[0] = 1'b1;
        push_raw(0, ex);
        send(0, to_st(pl), 30);
        wait_drain(0);
        rnd_rdy[0] = 1'b0;
        chk("bp_frames", 32'(frames[0]), 32'(exp_frames[0]));
        step(); step();

        // Back-to-back frames with no source gaps
        push_raw(0, ex);
        push_raw(0, ex);
        st = to_st(pl);
        foreach (pl[i]) st.push_back({i == pl.size() - 1, pl[i]});
        fork
            send(0, st, 0);
            begin
                int n, l, g, w;
                n = 0; l = 0; g = 0; w = 0;
                @(negedge CLK);
                while (!m_valid[0] && w < 100) begin
                    @(negedge CLK);
                    w++;
                end
                forever begin
                    if (!(m_valid[0] && m_ready[0])) g++;
                    n++;
                    if (m_valid[0] && m_ready[0] && m_last[0]) l++;
                    if (l == 2 || n > 100) break;
                    @(negedge CLK);
                end
                chk("b2b_cycles", n, 32'd26);
                chk("b2b_gaps", g, 32'd0);
            end
        join
        wait_drain(0);
        chk("b2b_frames", 32'(frames[0]), 32'(exp_frames[0]));
        step();

        // Random frames on both instances, padding boundaries on the 60-byte one
        for (int k = 0; k < 2; k++) begin
            st.delete();
            rnd_rdy[k] = 1'b1;
            for (int f = 0; f < 4; f++) begin
                int len;
                if (k == 1) len = (f < 3) ? 59 + f : int'($urandom_range(1, 80));
                else        len = int'($urandom_range(1, 20));
                pl.delete();
                for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
                push_frame(k, pl, k == 1 ? 60 : 0);
                foreach (pl[i]) st.push_back({i == pl.size() - 1, pl[i]});
            end
            send(k, st, 20);
            wait_drain(k);
            rnd_rdy[k] = 1'b0;
            chk($sformatf("rand_frames dut%0d", k), 32'(frames[k]), 32'(exp_frames[k]));
            step(); step();
        end

        // Reset after FCS byte 1 abandons the frame
        pl = kv_payload();
        foreach (pl[i]) push_exp(0, {1'b0, pl[i]});
        push_exp(0, {1'b0, 8'h26});
        push_exp(0, {1'b0, 8'h39});
        send(0, to_st(pl), 0);
        step();
        step();
        RST = 1'b1;
        s_data[0] = 8'h55; s_valid[0] = 1'b1;
        exp_frames[0] = 0; exp_frames[1] = 0;
        step();
        RST = 1'b0;
        s_valid[0] = 1'b0;
        chk("rst_abandon_pending", q0.size(), 32'd0);
        q0.delete();
        @(negedge CLK);
        chk("rst_mid_frames", 32'(frames[0]), 32'd0);
        chk("rst_mid_busy", 32'(busy[0]), 32'd0);
        step();
        pl.delete(); pl.push_back(8'h00);
        ex = pl;
        ex.push_back(8'h8D); ex.push_back(8'hEF); ex.push_back(8'h02); ex.push_back(8'hD2);
        push_raw(0, ex);
        send(0, to_st(pl), 0);
        wait_drain(0);
        chk("post_rst_frames", 32'(frames[0]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
